// File: rtl/encoder_pkg.sv
// Shared types and widths for the scanning 8-to-3 priority encoder.
package encoder_pkg;

   localparam int unsigned REQ_W  = 8;
   localparam int unsigned CODE_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder with selectable scan order.
module prio_enc8
   import encoder_pkg::*;
(
   input  logic [REQ_W-1:0]  vec,
   input  logic              msb_first,
   output logic [CODE_W-1:0] idx,
   output logic              any,
   output logic              single
);

   // Later loop iterations overwrite earlier ones, so the last set bit visited wins.
   always_comb begin
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (msb_first) begin
            if (vec[i]) idx = CODE_W'(i);
         end else begin
            if (vec[7-i]) idx = CODE_W'(7 - i);
         end
      end
   end

   // Any-set and exactly-one-set flags.
   always_comb begin
      any    = (vec != '0);
      single = any && ((vec & (vec - REQ_W'(1))) == '0);
   end

endmodule

// File: rtl/encoder_8x3_scan.sv
// Scanning 8-to-3 encoder: captures a request vector and emits one index per
// accepted handshake. Optional parity output enabled by macro ENC_PARITY_EN.
module encoder_8x3_scan
   import encoder_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              LOAD,
   input  logic [REQ_W-1:0]  REQ,
   input  logic              READY,
   output logic              VALID,
   output logic [CODE_W-1:0] CODE,
   output logic              LAST,
   output logic              BUSY,
   output logic              NONE
`ifdef ENC_PARITY_EN
   ,
   output logic              PAR
`endif
);

   state_t             state_q, state_d;
   logic [REQ_W-1:0]   pend_q, pend_d;
   logic               none_q, none_d;
   logic [CODE_W-1:0]  idx;
   logic               any, single;
   logic               scan_valid;

   prio_enc8 u_prio (
      .vec       (pend_q),
      .msb_first (MSB_FIRST),
      .idx       (idx),
      .any       (any),
      .single    (single)
   );

   // State, pending-bit and empty-load flag registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         pend_q  <= '0;
         none_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         none_q  <= none_d;
      end
   end

   // Next-state: capture on load, retire one bit per transfer, abort on !EN.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      none_d  = 1'b0;
      if (!EN) begin
         state_d = IDLE;
         pend_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (LOAD) begin
                  if (REQ != '0) begin
                     pend_d  = REQ;
                     state_d = SCAN;
                  end else begin
                     none_d  = 1'b1;
                  end
               end
            end
            SCAN: begin
               if (READY) begin
                  pend_d = pend_q & ~(REQ_W'(1) << idx);
                  if (single) state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               pend_d  = '0;
            end
         endcase
      end
   end

   // Outputs decode registered state only; nothing flows from inputs.
   always_comb begin
      scan_valid = (state_q == SCAN) && any;
      VALID      = scan_valid;
      BUSY       = (state_q == SCAN);
      CODE       = scan_valid ? idx : '0;
      LAST       = scan_valid && single;
      NONE       = none_q;
   end

`ifdef ENC_PARITY_EN
   // Parity of the presented code, forced low when nothing is presented.
   always_comb begin
      PAR = scan_valid && (^idx);
   end
`endif

endmodule

// File: doc/encoder_8x3_scan.md
ENCODER_8X3_SCAN -- requirements
Module: encoder_8x3_scan

Interface
REQ-001 Parameter MSB_FIRST, default 1, scan order: 1 = bit 7 down to bit 0, 0 = bit 0 up to bit 7.
REQ-002 CLK  input  1  sole clock, all state on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 EN  input  1  block enable; low aborts any scan and holds outputs inactive.
REQ-005 LOAD  input  1  capture request vector (sampled only when idle).
REQ-006 REQ  input  8  request lines to be encoded.
REQ-007 READY  input  1  downstream accepts CODE this cycle.
REQ-008 VALID  output  1  CODE holds a valid encoded index.
REQ-009 CODE  output  3  binary index of the current highest-priority pending bit.
REQ-010 LAST  output  1  current CODE is the final pending bit of the captured vector.
REQ-011 BUSY  output  1  scan in progress (state SCAN).
REQ-012 NONE  output  1  one-cycle pulse: LOAD captured an all-zero vector.

Function
REQ-013 States: IDLE, SCAN; internal 8-bit PEND register holds bits not yet emitted.
REQ-014 IDLE, EN=1, LOAD=1, REQ!=0: PEND<=REQ, next state SCAN; VALID=1 with first CODE on the following cycle (latency 1).
REQ-015 IDLE, EN=1, LOAD=1, REQ==0: PEND unchanged (0), state stays IDLE, NONE=1 for exactly the next cycle.
REQ-016 LOAD while BUSY=1 is ignored; REQ changes during SCAN have no effect.
REQ-017 SCAN: VALID=1, BUSY=1, CODE = index of first set PEND bit in MSB_FIRST order, LAST=1 iff PEND has exactly one bit set.
REQ-018 Transfer = VALID & READY; on transfer the encoded bit is cleared in PEND; if it was LAST, next state IDLE.
REQ-019 READY low: VALID, CODE, LAST held stable, PEND unchanged.
REQ-020 READY held high: one code per cycle; an n-bit vector completes in n cycles after the first VALID.
REQ-021 Back-to-back: LOAD asserted in the cycle after the LAST transfer is captured normally (no dead cycle beyond the IDLE cycle).
REQ-022 EN=0 in any state: next cycle state IDLE, PEND=0, VALID/LAST/BUSY/NONE=0, CODE=0.
REQ-023 Outputs depend only on registered state; no combinational path from any input to any output.
REQ-024 In IDLE: VALID=0, LAST=0, BUSY=0, CODE=0.

Reset
REQ-025 RST=1 asynchronously forces state IDLE, PEND=0, VALID=0, CODE=0, LAST=0, BUSY=0, NONE=0.
REQ-026 RST asserted mid-scan discards all pending bits; no further VALID until a new LOAD after RST release.
REQ-027 First LOAD sampled on the first rising CLK edge with RST=0.

Configuration
REQ-028 Macro ENC_PARITY_EN defined: extra output PAR (1 bit) = XOR of CODE[2:0], qualified by VALID, 0 when VALID=0 and at reset.
REQ-029 Macro ENC_PARITY_EN undefined: port PAR and its logic absent; all other behaviour identical.

Structure
REQ-030 Shared package encoder_pkg holds state typedef (IDLE, SCAN), REQ width constant 8 and CODE width constant 3.
REQ-031 Combinational sub-module prio_enc8 (8-bit vector + order select -> 3-bit index, any-set flag, single-set flag) is instantiated once on PEND.

Verification
REQ-032 RST then LOAD=1, REQ=8'b1010_0101, MSB_FIRST=1, READY=1 -> CODE 7,5,2,0 on consecutive cycles, LAST=1 only with CODE=0, then IDLE.
REQ-033 Same vector, MSB_FIRST=0 -> CODE 0,2,5,7; LAST with 7.
REQ-034 LOAD REQ=8'h00 -> NONE=1 one cycle, VALID never asserted, BUSY=0.
REQ-035 REQ=8'h81, READY low 3 cycles after first VALID -> CODE=7 held stable 3 cycles; REQ changed to 8'hFF meanwhile has no effect; then 7,0.
REQ-036 Mid-scan of 8'hFF after 2 transfers: EN=0 one cycle -> VALID=0 next cycle, PEND=0; same test with RST pulse -> immediate VALID=0.
REQ-037 With ENC_PARITY_EN, REQ=8'h48, MSB_FIRST=1 -> CODE=6 PAR=0, CODE=3 PAR=0; REQ=8'h10 -> CODE=4 PAR=1.
